// File: rtl/multi_shoot_timer_pkg.sv
// Shared types and constants for the multi-channel shot timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shoot_timer_pkg;

    // Per-channel countdown state.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } ch_state_t;

    // Jitter LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Upper bound on channel count supported by the arbiter index width.
    localparam int MAX_CH = 16;

    // One LFSR step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/multi_shoot_timer_rr_arbiter.sv
// Round-robin grant of one pending channel per cycle, search starts after last grant.
// Latency: grant is combinational from req/ready; pointer updates on the granting edge.
// Backpressure: no grant while ready is low; requests simply wait.
module shoot_rr_arbiter
    import shoot_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [NUM_CH-1:0] req,
    input  logic              ready,
    output logic              gnt_vld,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [IDX_W-1:0] last_grant;

    // Candidate channel 'off' positions after 'base', wrapping at NUM_CH.
    function automatic int wrap_add(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return s;
    endfunction

    // Pick the first requesting channel scanning upward from last_grant+1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!gnt_vld && ready && req[wrap_add(int'(last_grant), i)]) begin
                gnt_vld = 1'b1;
                gnt_oh[wrap_add(int'(last_grant), i)] = 1'b1;
                gnt_idx = IDX_W'(wrap_add(int'(last_grant), i));
            end
        end
    end

    // Remember the winner; reset points at the top channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_grant <= IDX_W'(NUM_CH - 1);
        end else if (gnt_vld) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/multi_shoot_timer.sv
// Multi-channel periodic/one-shot shot timer with round-robin shot issue; optional SHOOT_JITTER_EN adds LFSR jitter to loads.
// Latency: pending set P+1 edges after load, fire_o registered one edge after pending (earliest E0+P+2).
// Backpressure: fire_ready_i low holds shots pending; expiry on an ungranted pending channel sets sticky overrun.
module multi_shoot_timer
    import shoot_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 26,
    parameter  int JIT_W  = 4,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       oneshot_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic                    fire_ready_i,
    output logic                    fire_o,
    output logic [IDX_W-1:0]        fire_ch_o,
    output logic [NUM_CH-1:0]       pending_o,
    output logic [NUM_CH-1:0]       overrun_o
);

    logic              gnt_vld;
    logic [NUM_CH-1:0] gnt_oh;
    logic [IDX_W-1:0]  gnt_idx;
    logic [JIT_W-1:0]  jit;

`ifdef SHOOT_JITTER_EN
    logic [15:0] lfsr;

    // Free-running jitter source, advances every cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign jit = lfsr[JIT_W-1:0];
`else
    assign jit = '0;
`endif

    shoot_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .resetN  (resetN),
        .req     (pending_o),
        .ready   (fire_ready_i),
        .gnt_vld (gnt_vld),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             os_q;
        logic             pend_q;
        logic             ovr_q;
        logic [CNT_W-1:0] period_k;
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] load_val;
        logic             load_ok;

        assign period_k = period_i[k*CNT_W +: CNT_W];
        // Saturating period + jitter (jitter is zero when the feature is off).
        assign sum      = {1'b0, period_k} + (CNT_W+1)'(jit);
        assign load_val = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        // Periodic channels load on enable alone; one-shot ones need a start pulse.
        assign load_ok  = oneshot_i[k] ? start_i[k] : 1'b1;

        // Channel FSM: load, count down, flag expiry; disable wins over everything.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state  <= IDLE;
                cnt    <= '0;
                os_q   <= 1'b0;
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else if (!en_i[k]) begin
                state  <= IDLE;
                cnt    <= '0;
                pend_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_ok) begin
                            state <= COUNT;
                            cnt   <= load_val;
                            os_q  <= oneshot_i[k];
                        end
                        if (gnt_oh[k]) pend_q <= 1'b0;
                    end
                    COUNT: begin
                        if (cnt == '0) begin
                            // New expiry keeps pending set even if granted this edge.
                            pend_q <= 1'b1;
                            if (pend_q && !gnt_oh[k]) ovr_q <= 1'b1;
                            if (os_q) begin
                                state <= IDLE;
                            end else begin
                                cnt <= load_val;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                            if (gnt_oh[k]) pend_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign pending_o[k] = pend_q;
        assign overrun_o[k] = ovr_q;
    end

    // Register the shot strobe and its channel; index holds between shots.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_o    <= 1'b0;
            fire_ch_o <= '0;
        end else begin
            fire_o <= gnt_vld;
            if (gnt_vld) fire_ch_o <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_multi_shoot_timer.sv
// Directed self-checking bench for multi_shoot_timer (NUM_CH=4, CNT_W=26).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected cycle numbers are counted from the load edge E0.
module tb_multi_shoot_timer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 26;
    localparam int JIT_W  = 4;

    logic                    clk;
    logic                    resetN;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH-1:0]       oneshot_i;
    logic [NUM_CH-1:0]       start_i;
    logic [NUM_CH*CNT_W-1:0] period_i;
    logic                    fire_ready_i;
    logic                    fire_o;
    logic [1:0]              fire_ch_o;
    logic [NUM_CH-1:0]       pending_o;
    logic [NUM_CH-1:0]       overrun_o;

    int n_checks = 0;
    int n_fail   = 0;

    multi_shoot_timer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .JIT_W  (JIT_W)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .en_i         (en_i),
        .oneshot_i    (oneshot_i),
        .start_i      (start_i),
        .period_i     (period_i),
        .fire_ready_i (fire_ready_i),
        .fire_o       (fire_o),
        .fire_ch_o    (fire_ch_o),
        .pending_o    (pending_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en_i         = '0;
        oneshot_i    = '0;
        start_i      = '0;
        period_i     = '0;
        fire_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        resetN = 1'b0;
        #3;
        n_checks++; if (fire_o !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %0b expected 0", fire_o); end
        n_checks++; if (fire_ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_fire_ch: got %0d expected 0", fire_ch_o); end
        n_checks++; if (pending_o !== 4'h0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", pending_o); end
        n_checks++; if (overrun_o !== 4'h0) begin n_fail++; $display("FAIL reset_overrun: got %0h expected 0", overrun_o); end
        tick();
        resetN = 1'b1;
        tick();
    endtask

    // ch0 periodic P=3: first shot at E0+5, then every 4 cycles.
    task automatic test_periodic();
        logic exp_fire;
        do_reset();
        period_i[0*CNT_W +: CNT_W] = 26'd3;
        en_i[0] = 1'b1;
        tick();
        for (int c = 1; c <= 17; c++) begin
            tick();
            exp_fire = (c >= 5) && (((c - 5) % 4) == 0);
            n_checks++;
            if (fire_o !== exp_fire) begin n_fail++; $display("FAIL periodic_fire c=%0d: got %0b expected %0b", c, fire_o, exp_fire); end
            if (exp_fire) begin
                n_checks++;
                if (fire_ch_o !== 2'd0) begin n_fail++; $display("FAIL periodic_ch c=%0d: got %0d expected 0", c, fire_ch_o); end
            end
        end
        n_checks++; if (overrun_o !== 4'h0) begin n_fail++; $display("FAIL periodic_overrun: got %0h expected 0", overrun_o); end
    endtask

    // ch1 one-shot P=5: single shot at E0+7; a start at edge 3 is ignored.
    task automatic test_oneshot();
        int fires;
        logic exp_fire;
        do_reset();
        fires = 0;
        period_i[1*CNT_W +: CNT_W] = 26'd5;
        oneshot_i[1] = 1'b1;
        en_i[1]      = 1'b1;
        start_i[1]   = 1'b1;
        tick();
        start_i[1] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start_i[1] = (c == 2);
            exp_fire = (c == 7);
            if (fire_o) fires++;
            n_checks++;
            if (fire_o !== exp_fire) begin n_fail++; $display("FAIL oneshot_fire c=%0d: got %0b expected %0b", c, fire_o, exp_fire); end
            if (exp_fire) begin
                n_checks++;
                if (fire_ch_o !== 2'd1) begin n_fail++; $display("FAIL oneshot_ch: got %0d expected 1", fire_ch_o); end
            end
        end
        n_checks++; if (fires != 1) begin n_fail++; $display("FAIL oneshot_count: got %0d expected 1", fires); end
        n_checks++; if (pending_o !== 4'h0) begin n_fail++; $display("FAIL oneshot_pending: got %0h expected 0", pending_o); end
    endtask

    // All channels P=2, ready low for 10 cycles: grants 0,1,2,3 back to back, all overrun.
    task automatic test_round_robin();
        do_reset();
        fire_ready_i = 1'b0;
        for (int k = 0; k < NUM_CH; k++) period_i[k*CNT_W +: CNT_W] = 26'd2;
        en_i = 4'hF;
        tick();
        for (int c = 1; c <= 10; c++) tick();
        n_checks++; if (fire_o !== 1'b0) begin n_fail++; $display("FAIL rr_hold_fire: got %0b expected 0", fire_o); end
        n_checks++; if (pending_o !== 4'hF) begin n_fail++; $display("FAIL rr_pending: got %0h expected f", pending_o); end
        n_checks++; if (overrun_o !== 4'hF) begin n_fail++; $display("FAIL rr_overrun: got %0h expected f", overrun_o); end
        fire_ready_i = 1'b1;
        for (int g = 0; g < NUM_CH; g++) begin
            tick();
            n_checks++;
            if (fire_o !== 1'b1 || fire_ch_o !== 2'(g)) begin
                n_fail++; $display("FAIL rr_order g=%0d: got fire=%0b ch=%0d expected fire=1 ch=%0d", g, fire_o, fire_ch_o, g);
            end
        end
        en_i = '0;
        tick();
        n_checks++; if (pending_o !== 4'h0) begin n_fail++; $display("FAIL rr_disable_pending: got %0h expected 0", pending_o); end
        n_checks++; if (overrun_o !== 4'hF) begin n_fail++; $display("FAIL rr_overrun_sticky: got %0h expected f", overrun_o); end
    endtask

    // ch2 P=100 disabled at cycle 50: no shot; re-enable reloads full period (shot at E1+102).
    task automatic test_disable();
        int fires;
        int first;
        do_reset();
        fires = 0;
        period_i[2*CNT_W +: CNT_W] = 26'd100;
        en_i[2] = 1'b1;
        tick();
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (fire_o) fires++;
        end
        en_i[2] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (fire_o) fires++;
        end
        n_checks++; if (fires != 0) begin n_fail++; $display("FAIL disable_fires: got %0d expected 0", fires); end
        n_checks++; if (pending_o[2] !== 1'b0) begin n_fail++; $display("FAIL disable_pending: got %0b expected 0", pending_o[2]); end
        en_i[2] = 1'b1;
        tick();
        first = -1;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (fire_o) begin
                fires++;
                if (first < 0) first = c;
            end
        end
        n_checks++; if (first != 102) begin n_fail++; $display("FAIL reenable_first: got %0d expected 102", first); end
        n_checks++; if (fires != 1) begin n_fail++; $display("FAIL reenable_count: got %0d expected 1", fires); end
    endtask

    // ch3 P=0: shot every cycle from E0+2, no overrun; async reset clears outputs at once.
    task automatic test_boundary();
        logic exp_fire;
        do_reset();
        en_i[3] = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_fire = (c >= 2);
            n_checks++;
            if (fire_o !== exp_fire) begin n_fail++; $display("FAIL p0_fire c=%0d: got %0b expected %0b", c, fire_o, exp_fire); end
            if (exp_fire) begin
                n_checks++;
                if (fire_ch_o !== 2'd3) begin n_fail++; $display("FAIL p0_ch c=%0d: got %0d expected 3", c, fire_ch_o); end
            end
        end
        n_checks++; if (overrun_o !== 4'h0) begin n_fail++; $display("FAIL p0_overrun: got %0h expected 0", overrun_o); end
        n_checks++; if (pending_o !== 4'h8) begin n_fail++; $display("FAIL p0_pending: got %0h expected 8", pending_o); end
        #1;
        resetN = 1'b0;
        #1;
        n_checks++; if (fire_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_fire: got %0b expected 0", fire_o); end
        n_checks++; if (fire_ch_o !== 2'd0) begin n_fail++; $display("FAIL async_rst_ch: got %0d expected 0", fire_ch_o); end
        n_checks++; if (pending_o !== 4'h0) begin n_fail++; $display("FAIL async_rst_pending: got %0h expected 0", pending_o); end
        n_checks++; if (overrun_o !== 4'h0) begin n_fail++; $display("FAIL async_rst_overrun: got %0h expected 0", overrun_o); end
        tick();
        resetN = 1'b1;
        tick();
    endtask

    // ch0 P=10: exact 11-cycle interval, or 11..26 when jitter is built in.
    task automatic test_jitter();
        int last;
        int ivl;
        int seen;
        do_reset();
        period_i[0*CNT_W +: CNT_W] = 26'd10;
        en_i[0] = 1'b1;
        tick();
        last = 0;
        seen = 0;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (fire_o) begin
                seen++;
                if (last != 0) begin
                    ivl = c - last;
`ifdef SHOOT_JITTER_EN
                    n_checks++;
                    if (ivl < 11 || ivl > 26) begin n_fail++; $display("FAIL jitter_interval: got %0d expected 11..26", ivl); end
`else
                    n_checks++;
                    if (ivl != 11) begin n_fail++; $display("FAIL exact_interval: got %0d expected 11", ivl); end
`endif
                end else begin
`ifndef SHOOT_JITTER_EN
                    n_checks++;
                    if (c != 12) begin n_fail++; $display("FAIL exact_first: got %0d expected 12", c); end
`endif
                end
                last = c;
            end
        end
        n_checks++; if (seen < 5) begin n_fail++; $display("FAIL jitter_shots: got %0d expected at least 5", seen); end
    endtask

    initial begin
        clear_inputs();
        resetN = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_round_robin();
        test_disable();
        test_boundary();
        test_jitter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
